// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with a drain sequencer feeding the UART transmitter.
// Bytes are popped one per frame using a tx_valid pulse / tx_ready level handshake.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        mem [DEPTH];
    logic              push, pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (ADDR_W+1)'(DEPTH));
    assign wr_ready = !full;
    assign busy     = !empty || (state_q != IDLE);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        overflow_d = overflow_q;
        pop        = 1'b0;
        push       = wr_en && wr_ready && !flush;

        // flush suppresses the launch so no byte escapes a cleared FIFO
        case (state_q)
            IDLE: if (!empty && tx_ready && !flush) begin
                pop        = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = mem[rd_ptr_q];
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: if (!tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (tx_ready)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + (ADDR_W+1)'(1);
                2'b01:   level_d = level_q - (ADDR_W+1)'(1);
                default: level_d = level_q;
            endcase
        end

        // a new overflow event beats a same-cycle clear
        if (wr_en && full)  overflow_d = 1'b1;
        else if (ovf_clr)   overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, ordering, overflow, wrap, flush, reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst, wr_en, flush, ovf_clr, tx_ready;
    logic [7:0] wr_data;
    logic       wr_ready, empty, full, overflow, busy, tx_valid;
    logic [4:0] level;
    logic [7:0] tx_data;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
        .flush(flush), .ovf_clr(ovf_clr), .level(level), .empty(empty), .full(full),
        .overflow(overflow), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ticks until tx_valid is seen, bounded; returns number of edges waited
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_valid && n < 5000);
    endtask

    // counts tx_valid pulses over a window of edges
    task automatic hold(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (tx_valid) pulses++;
        end
    endtask

    int n, p;
    logic [7:0] exp_b;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0; tx_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);

        // single byte latency
        wr_data = 8'h41; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("t1_level_after_write", level, 1);
        chk("t1_valid_early", tx_valid, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_valid", tx_valid, 1);
        chk("t1_data", tx_data, 8'h41);
        chk("t1_level_after_pop", level, 0);
        tick();
        chk("t1_valid_one_cycle", tx_valid, 0);
        chk("t1_busy_wait_busy", busy, 1);
        tx_ready = 1'b0;
        tick();
        chk("t1_busy_wait_done", busy, 1);
        tx_ready = 1'b1;
        tick();
        chk("t1_busy_idle", busy, 0);

        // "ABC" with a slow transmitter
        wr_data = 8'h41; wr_en = 1'b1;
        tick();
        wr_data = 8'h42;
        tick();
        chk("t2_valid_a", tx_valid, 1);
        chk("t2_data_a", tx_data, 8'h41);
        wr_data = 8'h43; tx_ready = 1'b0;
        tick();
        wr_en = 1'b0;
        chk("t2_level", level, 2);
        hold(2342, p);
        chk("t2_no_pulse_a", p, 0);
        tx_ready = 1'b1;
        wait_valid(n);
        chk("t2_lat_b", n, 2);
        chk("t2_data_b", tx_data, 8'h42);
        tx_ready = 1'b0;
        hold(2343, p);
        chk("t2_no_pulse_b", p, 0);
        tx_ready = 1'b1;
        wait_valid(n);
        chk("t2_lat_c", n, 2);
        chk("t2_data_c", tx_data, 8'h43);
        tx_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        tick();
        chk("t2_idle_busy", busy, 0);
        chk("t2_level_end", level, 0);

        // fill to full and overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h10 + 8'(i); wr_en = 1'b1;
            tick();
        end
        chk("t3_full", full, 1);
        chk("t3_wr_ready", wr_ready, 0);
        chk("t3_level16", level, 16);
        chk("t3_no_ovf_yet", overflow, 0);
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("t3_overflow", overflow, 1);
        chk("t3_level_still16", level, 16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_cleared", overflow, 0);
        ovf_clr = 1'b1; wr_en = 1'b1;
        tick();
        ovf_clr = 1'b0; wr_en = 1'b0;
        chk("t3_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_cleared2", overflow, 0);

        // pop and refused write at full, then wrap
        tx_ready = 1'b1; wr_data = 8'hAA; wr_en = 1'b1;
        tick();
        chk("t4_valid", tx_valid, 1);
        chk("t4_data", tx_data, 8'h10);
        chk("t4_level15", level, 15);
        tx_ready = 1'b0; wr_data = 8'hAB;
        tick();
        wr_en = 1'b0;
        chk("t4_level16", level, 16);
        for (int i = 1; i <= 16; i++) begin
            exp_b = (i == 16) ? 8'hAB : 8'h10 + 8'(i);
            tx_ready = 1'b1;
            wait_valid(n);
            chk("t4_drain_lat", n, 2);
            chk("t4_drain_data", tx_data, exp_b);
            tx_ready = 1'b0;
            tick();
        end
        tx_ready = 1'b1;
        tick();
        chk("t4_empty", empty, 1);
        chk("t4_busy", busy, 0);

        // flush with a frame in flight
        wr_en = 1'b1;
        wr_data = 8'h60;
        tick();
        wr_data = 8'h61;
        tick();
        chk("t5_valid", tx_valid, 1);
        chk("t5_data", tx_data, 8'h60);
        tx_ready = 1'b0;
        for (int i = 2; i < 6; i++) begin
            wr_data = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t5_level5", level, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_level", level, 0);
        chk("t5_flush_empty", empty, 1);
        chk("t5_inflight_busy", busy, 1);
        tx_ready = 1'b1;
        hold(10, p);
        chk("t5_no_more_valid", p, 0);
        chk("t5_busy_done", busy, 0);

        // flush beats same-cycle pop and write
        tx_ready = 1'b0; wr_data = 8'h70; wr_en = 1'b1;
        tick();
        chk("t5b_level1", level, 1);
        tx_ready = 1'b1; flush = 1'b1; wr_data = 8'h71;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("t5b_no_valid", tx_valid, 0);
        chk("t5b_level0", level, 0);
        tick();
        chk("t5b_still_no_valid", tx_valid, 0);

        // reset mid-stream, FSM stuck in WAIT_BUSY with tx_ready high
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h80 + 8'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        chk("t6_level7", level, 7);
        chk("t6_no_retry", tx_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_level", level, 0);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_wr_ready", wr_ready, 1);
        tick();
        chk("t6_no_valid_after", tx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
